// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit common-anode display scan controller with double-buffered data
//
// Purpose:
//   Time-multiplexes one BCD-to-7-segment decoder across four digits.
//   Each digit slot is REFRESH_DIV cycles long. The first BLANK_CYC cycles
//   of a slot keep all anodes off. Leading zeros can be suppressed by
//   driving code 4'hF. A pending/active register pair makes sure a frame
//   never shows a mix of old and new data.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable
//   load       in   strobe that captures value/dot_en/dot_pos/blank_lz
//   value      in   four BCD nibbles, value[3:0] is digit 0 (rightmost)
//   dot_en     in   decimal point enable
//   dot_pos    in   digit index that carries the decimal point
//   blank_lz   in   leading-zero suppression enable
//   digit_code out  nibble to the decoder (4'hF = all segments off)
//   digit_dot  out  decoder dot input, 1 lights the dp
//   an         out  active-low anode enables, an[i] drives digit i
//   frame_tick out  one-cycle pulse when pending data is committed
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        dot_en,
  input  logic [1:0]  dot_pos,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic        digit_dot,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  // Config word layout: {blank_lz, dot_pos, dot_en, value}
  logic [19:0]   pend_q, pend_d;
  logic [19:0]   act_q,  act_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [1:0]    idx_q,  idx_d;
  logic          state_q, state_d;
  logic          en_q;
  logic [3:0]    an_q,   an_d;
  logic [3:0]    code_q, code_d;
  logic          dot_q,  dot_d;
  logic          tick_q, tick_d;

  logic [19:0]   load_cfg;
  logic          commit;

  assign load_cfg = {blank_lz, dot_pos, dot_en, value};

  // Pending/active buffering. On a commit cycle a simultaneous load goes
  // straight through pend_d into active, so the new frame already uses it.
  always_comb begin
    pend_d = load ? load_cfg : pend_q;
    commit = en && (!en_q || (cnt_q == CNT_MAX && idx_q == 2'd3));
    act_d  = commit ? pend_d : act_q;
  end

  // Digit selection for the upcoming index, using the post-commit data.
  logic [15:0] a_val;
  logic        a_de;
  logic [1:0]  a_dp;
  logic        a_lz;
  logic [3:0]  nib;
  logic        upper_zero;
  logic        lz_blank;
  logic [3:0]  sel_code;
  logic        sel_dot;

  assign a_val = act_d[15:0];
  assign a_de  = act_d[16];
  assign a_dp  = act_d[18:17];
  assign a_lz  = act_d[19];

  always_comb begin
    nib        = a_val[3:0];
    upper_zero = 1'b0;
    case (idx_d)
      2'd0: begin nib = a_val[3:0];   upper_zero = 1'b0;              end
      2'd1: begin nib = a_val[7:4];   upper_zero = (a_val[15:4]  == '0); end
      2'd2: begin nib = a_val[11:8];  upper_zero = (a_val[15:8]  == '0); end
      default: begin nib = a_val[15:12]; upper_zero = (a_val[15:12] == '0); end
    endcase
    // A zero that carries or precedes the dot is significant and stays lit.
    lz_blank = a_lz && upper_zero && !(a_de && (a_dp >= idx_d));
    sel_code = lz_blank ? 4'hF : nib;
    sel_dot  = a_de && (a_dp == idx_d);
  end

  // Slot sequencing and output next-state.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    an_d    = an_q;
    code_d  = code_q;
    dot_d   = dot_q;
    tick_d  = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      state_d = ST_BLANK;
      an_d    = 4'b1111;
      code_d  = 4'hF;
      dot_d   = 1'b0;
    end else begin
      if (!en_q) begin
        cnt_d = '0;
        idx_d = 2'd0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      tick_d  = commit;
      state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
      an_d    = (state_d == ST_BLANK) ? 4'b1111 : ~(4'b0001 << idx_d);
      // Code/dot change only on entry to BLANK: from the previous SHOW or
      // from the idle state when the scan (re)starts.
      if (state_d == ST_BLANK && (state_q == ST_SHOW || !en_q)) begin
        code_d = sel_code;
        dot_d  = sel_dot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      state_q <= ST_BLANK;
      en_q    <= 1'b0;
      an_q    <= 4'b1111;
      code_q  <= 4'hF;
      dot_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      en_q    <= en;
      an_q    <= an_d;
      code_q  <= code_d;
      dot_q   <= dot_d;
      tick_q  <= tick_d;
    end
  end

  assign digit_code = code_q;
  assign digit_dot  = dot_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        dot_en;
  logic [1:0]  dot_pos;
  logic        blank_lz;
  logic [3:0]  digit_code;
  logic        digit_dot;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dot_en(dot_en), .dot_pos(dot_pos), .blank_lz(blank_lz),
    .digit_code(digit_code), .digit_dot(digit_dot), .an(an),
    .frame_tick(frame_tick)
  );

  // Reference active-low decoder {dp, g..a}; codes 10..15 are all off.
  function automatic logic [7:0] seg_of(input logic [3:0] c, input logic dp);
    logic [6:0] s;
    case (c)
      4'd0: s = 7'h40; 4'd1: s = 7'h79; 4'd2: s = 7'h24; 4'd3: s = 7'h30;
      4'd4: s = 7'h19; 4'd5: s = 7'h12; 4'd6: s = 7'h02; 4'd7: s = 7'h78;
      4'd8: s = 7'h00; 4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return {~dp, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic de,
                         input logic [1:0] dp, input logic lz);
    value = v; dot_en = de; dot_pos = dp; blank_lz = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Starts at frame cycle 0, samples each digit mid-SHOW, ends at cycle 28.
  task automatic capture_frame(output logic [15:0] codes, output logic [3:0] dots,
                               output logic [15:0] ans);
    for (int i = 0; i < 4; i++) begin
      steps((i == 0) ? 4 : 8);
      codes[i*4 +: 4] = digit_code;
      dots[i]         = digit_dot;
      ans[i*4 +: 4]   = an;
    end
  endtask

  task automatic test_reset();
    bit got;
    logic [15:0] c, a;
    logic [3:0]  d;
    rst_n = 1'b1; en = 1'b0; load = 1'b0; value = '0;
    dot_en = 1'b0; dot_pos = 2'd0; blank_lz = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({an, digit_code, digit_dot, frame_tick} !== {4'b1111, 4'hF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got an=%b code=%h dot=%b tick=%b, want an=1111 code=f dot=0 tick=0",
               an, digit_code, digit_dot, frame_tick);
    end
    steps(2);
    rst_n = 1'b1; en = 1'b1;
    wait_tick(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL reset_first_tick: got no frame_tick, want one"); end
    n_checks++;
    if (an !== 4'b1111 || digit_code !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_cyc0: got an=%b code=%h, want an=1111 code=0", an, digit_code);
    end
    step();
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL blank_cyc1: got an=%b want 1111", an); end
    step();
    n_checks++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL show_cyc2: got an=%b want 1110", an); end
    steps(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (an !== 4'b1111 || digit_code !== 4'hF) begin
      n_fail++;
      $display("FAIL async_reset: got an=%b code=%h, want an=1111 code=f", an, digit_code);
    end
    #1 rst_n = 1'b1;
    wait_tick(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL reset_retick: got no frame_tick, want one"); end
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'h0000 || d !== 4'b0000 || a !== 16'h7BDE) begin
      n_fail++;
      $display("FAIL reset_frame: got codes=%h dots=%b an=%h, want codes=0000 dots=0000 an=7bde", c, d, a);
    end
  endtask

  task automatic test_load_commit();
    bit got;
    logic [15:0] c, a;
    logic [3:0]  d;
    wait_tick(got);
    steps(12);
    do_load(16'h1234, 1'b1, 2'd2, 1'b0);
    steps(7);
    n_checks++;
    if (digit_code !== 4'h0 || digit_dot !== 1'b0 || an !== 4'b1011) begin
      n_fail++;
      $display("FAIL frame_unchanged: got code=%h dot=%b an=%b, want code=0 dot=0 an=1011",
               digit_code, digit_dot, an);
    end
    wait_tick(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL commit_tick: got no frame_tick, want one"); end
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'h1234 || d !== 4'b0100) begin
      n_fail++;
      $display("FAIL load_1234: got codes=%h dots=%b, want codes=1234 dots=0100", c, d);
    end
  endtask

  task automatic test_leading_zero();
    bit got;
    logic [15:0] c, a;
    logic [3:0]  d;
    do_load(16'h0050, 1'b0, 2'd0, 1'b1);
    wait_tick(got);
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'hFF50 || d !== 4'b0000) begin
      n_fail++;
      $display("FAIL lz_0050: got codes=%h dots=%b, want codes=ff50 dots=0000", c, d);
    end
    do_load(16'h0005, 1'b1, 2'd1, 1'b1);
    wait_tick(got);
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'hFF05 || d !== 4'b0010) begin
      n_fail++;
      $display("FAIL lz_dot: got codes=%h dots=%b, want codes=ff05 dots=0010", c, d);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [15:0] c, a;
    logic [3:0]  d;
    do_load(16'h1111, 1'b0, 2'd0, 1'b0);
    do_load(16'h2222, 1'b0, 2'd0, 1'b0);
    wait_tick(got);
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'h2222) begin
      n_fail++;
      $display("FAIL last_wins: got codes=%h, want 2222", c);
    end
    steps(3);
    value = 16'h9999; dot_en = 1'b0; dot_pos = 2'd0; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_tick: got frame_tick=%b, want 1", frame_tick);
    end
    capture_frame(c, d, a);
    n_checks++;
    if (c !== 16'h9999) begin
      n_fail++;
      $display("FAIL bypass: got codes=%h, want 9999", c);
    end
  endtask

  task automatic test_enable();
    bit got;
    int bad;
    wait_tick(got);
    steps(20);
    n_checks++;
    if (an !== 4'b1011) begin n_fail++; $display("FAIL en_pre: got an=%b want 1011", an); end
    en = 1'b0;
    step();
    n_checks++;
    if (an !== 4'b1111 || digit_code !== 4'hF || digit_dot !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off: got an=%b code=%h dot=%b, want an=1111 code=f dot=0",
               an, digit_code, digit_dot);
    end
    do_load(16'h4321, 1'b0, 2'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (an !== 4'b1111 || frame_tick !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_hold: got %0d bad idle cycles, want 0", bad);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (frame_tick !== 1'b1 || an !== 4'b1111 || digit_code !== 4'h1) begin
      n_fail++;
      $display("FAIL en_rise: got tick=%b an=%b code=%h, want tick=1 an=1111 code=1",
               frame_tick, an, digit_code);
    end
    steps(2);
    n_checks++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL en_show: got an=%b want 1110", an); end
  endtask

  task automatic test_invalid_digit();
    bit got;
    do_load(16'h00A0, 1'b0, 2'd0, 1'b0);
    wait_tick(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL inv_tick: got no frame_tick, want one"); end
    steps(12);
    n_checks++;
    if (digit_code !== 4'hA || an !== 4'b1101) begin
      n_fail++;
      $display("FAIL inv_code: got code=%h an=%b, want code=a an=1101", digit_code, an);
    end
    n_checks++;
    if (seg_of(digit_code, digit_dot) !== 8'hFF) begin
      n_fail++;
      $display("FAIL inv_seg: got seg=%h, want ff", seg_of(digit_code, digit_dot));
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_leading_zero();
    test_back_to_back();
    test_enable();
    test_invalid_digit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
